// File: rtl/vedic_pkg.sv
// vedic_pkg: shared helpers for the Vedic multiplier (width checks, half width, negation)
// No ports; imported by vedic_core and vedic_mult_pipe.
package vedic_pkg;

    localparam int MAX_P = 128;
    localparam logic [MAX_P-1:0] ONE = 1;

    function automatic bit is_pow2(input int v);
        return v > 0 && (v & (v - 1)) == 0;
    endfunction

    function automatic int half_w(input int w);
        return w / 2;
    endfunction

    // Two's-complement negation of the low w bits; higher bits are cleared.
    function automatic logic [MAX_P-1:0] twos_neg(input logic [MAX_P-1:0] v, input int w);
        logic [MAX_P-1:0] m;
        m = (w >= MAX_P) ? '1 : (ONE << w) - ONE;
        return (~v + ONE) & m;
    endfunction

endpackage

// File: rtl/vedic_core.sv
// vedic_core: combinational recursive Urdhva-Tiryagbhyam N x N unsigned multiplier
// Ports: a, b (N-bit unsigned operands) -> p (2N-bit product).
module vedic_core
    import vedic_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);

    if (!is_pow2(N) || N < 2) begin : g_bad
        $error("vedic_core: N must be a power of two >= 2");
    end

    if (N == 2) begin : g_base
        logic c1;
        // The cross-product sum a1b0 + a0b1 carries only when all four bits are set.
        assign c1 = a[1] & b[0] & a[0] & b[1];
        assign p  = {a[1] & b[1] & c1, (a[1] & b[1]) ^ c1, (a[1] & b[0]) ^ (a[0] & b[1]), a[0] & b[0]};
    end else begin : g_rec
        localparam int M = N / 2;
        logic [N-1:0]   ll, lh, hl, hh;
        logic [2*N-1:0] mid;
        vedic_core #(.N(M)) u_ll (.a(a[M-1:0]), .b(b[M-1:0]), .p(ll));
        vedic_core #(.N(M)) u_lh (.a(a[M-1:0]), .b(b[N-1:M]), .p(lh));
        vedic_core #(.N(M)) u_hl (.a(a[N-1:M]), .b(b[M-1:0]), .p(hl));
        vedic_core #(.N(M)) u_hh (.a(a[N-1:M]), .b(b[N-1:M]), .p(hh));
        // Middle sum kept at full width so its carry is never lost.
        assign mid = (2*N)'(lh) + (2*N)'(hl);
        assign p   = {hh, ll} + (mid << M);
    end

endmodule

// File: rtl/vedic_mult_pipe.sv
// vedic_mult_pipe: 3-stage pipelined signed/unsigned Vedic multiplier with valid/ready and tag
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_a/in_b/in_signed/in_tag (operand side);
//        out_valid/out_ready/out_p/out_tag (product side).
module vedic_mult_pipe
    import vedic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int H  = half_w(WIDTH);
    localparam int PW = 2 * WIDTH;

    if (!is_pow2(WIDTH) || WIDTH < 4 || PW > MAX_P) begin : g_bad
        $error("vedic_mult_pipe: WIDTH must be a power of two >= 4");
    end

    logic             en, v1, v2, neg1, neg2;
    logic [TAG_W-1:0] tag1, tag2;
    logic [WIDTH-1:0] ma, mb, ll, lh, hl, hh, ll_c, lh_c, hl_c, hh_c;
    logic [PW-1:0]    prod;

    // The whole pipe freezes only when a held product is not being taken.
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;

    vedic_core #(.N(H)) u_ll (.a(ma[H-1:0]),     .b(mb[H-1:0]),     .p(ll_c));
    vedic_core #(.N(H)) u_lh (.a(ma[H-1:0]),     .b(mb[WIDTH-1:H]), .p(lh_c));
    vedic_core #(.N(H)) u_hl (.a(ma[WIDTH-1:H]), .b(mb[H-1:0]),     .p(hl_c));
    vedic_core #(.N(H)) u_hh (.a(ma[WIDTH-1:H]), .b(mb[WIDTH-1:H]), .p(hh_c));

    assign prod = {hh, ll} + ((PW'(lh) + PW'(hl)) << H);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            out_p     <= '0;
            out_tag   <= '0;
        end else if (en) begin
            v1        <= in_valid;
            v2        <= v1;
            out_valid <= v2;
            if (v2) begin
                out_p   <= neg2 ? PW'(twos_neg(MAX_P'(prod), PW)) : prod;
                out_tag <= tag2;
            end
        end
    end

    // Datapath registers of empty stages are don't-care, so they carry no reset.
    always_ff @(posedge clk) begin
        if (en) begin
            tag1 <= in_tag;
            neg1 <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
            // Negating the most negative value wraps to 2^(WIDTH-1), its correct unsigned magnitude.
            ma   <= (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
            mb   <= (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
            tag2 <= tag1;
            neg2 <= neg1;
            ll   <= ll_c;
            lh   <= lh_c;
            hl   <= hl_c;
            hh   <= hh_c;
        end
    end

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// tb_vedic_mult_pipe: directed table, streaming, stall, reset and random checks of vedic_mult_pipe
module tb_vedic_mult_pipe;

    localparam int W  = 16;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          in_signed = 1'b0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [2*W-1:0] out_p;
    logic [TW-1:0] out_tag;

    vedic_mult_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_signed(in_signed), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] p;
        logic [3:0]  t;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [3:0]  t;
        logic [31:0] p;
    } vec_t;

    exp_t q[$];
    logic [2:0] mv = '0;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
        logic signed [31:0] sa, sb;
        sa = s ? {{16{a[15]}}, a} : {16'b0, a};
        sb = s ? {{16{b[15]}}, b} : {16'b0, b};
        return sa * sb;
    endfunction

    // One cycle: drive at negedge, check outputs against the valid-bit model and scoreboard,
    // then advance the model to the state expected after the next rising edge.
    task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic [3:0] t, input logic [31:0] ep, input logic ordy, output logic acc);
        logic en_m;
        @(negedge clk);
        in_valid = v; in_a = a; in_b = b; in_signed = s; in_tag = t; out_ready = ordy;
        #1;
        en_m = !(mv[2] && !ordy);
        chk("in_ready", {31'b0, in_ready}, {31'b0, en_m});
        chk("out_valid", {31'b0, out_valid}, {31'b0, mv[2]});
        if (mv[2]) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: product expected but none queued");
            end else begin
                chk("out_p", out_p, q[0].p);
                chk("out_tag", {28'b0, out_tag}, {28'b0, q[0].t});
                if (ordy) void'(q.pop_front());
            end
        end
        acc = v && en_m;
        if (en_m) begin
            mv = {mv[1:0], v};
            if (v) q.push_back('{ep, t});
        end
    endtask

    initial begin
        vec_t tbl[11];
        logic acc;
        logic [15:0] ra, rb;
        logic rs;
        int i;
        int cyc;
        tbl[0]  = '{16'hFFFF, 16'hFFFF, 1'b0, 4'h3, 32'hFFFE0001};
        tbl[1]  = '{16'hFFFF, 16'hFFFF, 1'b1, 4'h1, 32'h00000001};
        tbl[2]  = '{16'h8000, 16'h0001, 1'b1, 4'h2, 32'hFFFF8000};
        tbl[3]  = '{16'h8000, 16'h8000, 1'b1, 4'h4, 32'h40000000};
        tbl[4]  = '{16'h0000, 16'h8000, 1'b1, 4'h5, 32'h00000000};
        tbl[5]  = '{16'h1234, 16'h5678, 1'b0, 4'h6, 32'h06260060};
        tbl[6]  = '{16'hFFFE, 16'h0003, 1'b1, 4'h7, 32'hFFFFFFFA};
        tbl[7]  = '{16'h8000, 16'hFFFF, 1'b0, 4'h8, 32'h7FFF8000};
        tbl[8]  = '{16'h7FFF, 16'h8000, 1'b1, 4'h9, 32'hC0008000};
        tbl[9]  = '{16'h00FF, 16'h0100, 1'b0, 4'hA, 32'h0000FF00};
        tbl[10] = '{16'h0003, 16'h0005, 1'b1, 4'hB, 32'h0000000F};

        #1;
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset out_p", out_p, 32'd0);
        chk("reset out_tag", {28'b0, out_tag}, 32'd0);
        chk("reset in_ready", {31'b0, in_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Isolated operations: output must appear on the third edge counting the acceptance edge.
        for (int k = 0; k < 11; k++) begin
            step(1'b1, tbl[k].a, tbl[k].b, tbl[k].s, tbl[k].t, tbl[k].p, 1'b1, acc);
            repeat (3) step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, acc);
        end

        // Back-to-back stream.
        for (int k = 0; k < 8; k++) begin
            ra = 16'(k * 257);
            rb = 16'(k + 1);
            step(1'b1, ra, rb, 1'b0, 4'(k), model(ra, rb, 1'b0), 1'b1, acc);
        end
        repeat (3) step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, acc);

        // Backpressure mid-burst: an op is held until the model says it was accepted.
        i = 0;
        cyc = 0;
        while (i < 10) begin
            ra = 16'(16'h1111 * (i + 1));
            rb = 16'(16'hF00D - i * 3);
            rs = 1'(i);
            step(1'b1, ra, rb, rs, 4'(i), model(ra, rb, rs), !(cyc >= 4 && cyc < 8), acc);
            if (acc) i++;
            cyc++;
        end
        repeat (4) step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, acc);

        // Asynchronous reset with operations in flight.
        step(1'b1, 16'h0011, 16'h0022, 1'b0, 4'hA, 32'h00000242, 1'b1, acc);
        step(1'b1, 16'h0033, 16'h0044, 1'b0, 4'hB, 32'h00000D8C, 1'b1, acc);
        step(1'b1, 16'h0055, 16'h0066, 1'b0, 4'hC, 32'h000021DE, 1'b1, acc);
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, acc);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("async reset out_p", out_p, 32'd0);
        chk("async reset out_tag", {28'b0, out_tag}, 32'd0);
        chk("async reset in_ready", {31'b0, in_ready}, 32'd1);
        mv = '0;
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 16'h00FF, 16'h0100, 1'b1, 4'h5, 32'h0000FF00, 1'b1, acc);
        repeat (5) step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, acc);

        // Random traffic with random backpressure.
        for (int k = 0; k < 400; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            step($urandom_range(0, 3) != 0, ra, rb, rs, 4'($urandom), model(ra, rb, rs),
                 $urandom_range(0, 3) != 0, acc);
        end
        repeat (4) step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, acc);
        chk("drained", q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
